// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared types, mode defaults and sizing helper for the SPI
//               slave endpoint.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    // Frame controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Default SPI mode (mode 0) and frame length
    localparam logic        c_cpol_default = 1'b0;
    localparam logic        c_cpha_default = 1'b0;
    localparam int unsigned c_n_default    = 20;

    // Bit counter width for an n-bit frame (at least one bit)
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync.sv
`default_nettype none
// ============================================================================
// Module      : spi_sync
// Description : Two-flop synchronizer for one asynchronous pad input with a
//               configurable reset (idle) level.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk_p,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic meta_q;
    logic sync_q;

    // Two-stage metastability filter, reset to the line's idle level
    always_ff @(posedge i_clk_p or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave
// Description : Oversampling SPI slave. Deserialises N-bit LSB-first MOSI
//               frames and serialises a preloaded word onto MISO.
//               Optional macro SPI_SLAVE_FRAME_ERR_EN adds o_frame_err.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave
    import spi_pkg::*;
#(
    parameter int   N    = c_n_default,
    parameter logic CPOL = c_cpol_default,
    parameter logic CPHA = c_cpha_default
) (
    input  logic         i_clk_p,
    input  logic         i_rst_n,
    input  logic         i_sclk,
    input  logic         i_cs_n,
    input  logic         i_mosi,
    output logic         o_miso,
    output logic         o_miso_oe,
    input  logic [N-1:0] i_tx_data,
    input  logic         i_tx_valid,
    output logic         o_tx_ready,
    output logic [N-1:0] o_rx_data,
    output logic         o_rx_valid,
    output logic         o_tx_underrun,
    output logic         o_busy
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ,
    output logic         o_frame_err
`endif
);

    localparam int             c_cw   = cnt_width(N);
    localparam logic [c_cw-1:0] c_last = c_cw'(N - 1);

    // Synchronised pad inputs
    logic sclk_s;
    logic cs_n_s;
    logic mosi_s;

    spi_sync #(.RESET_VAL(CPOL)) u_sync_sclk (
        .i_clk_p (i_clk_p),
        .i_rst_n (i_rst_n),
        .i_d     (i_sclk),
        .o_q     (sclk_s)
    );

    spi_sync #(.RESET_VAL(1'b1)) u_sync_cs_n (
        .i_clk_p (i_clk_p),
        .i_rst_n (i_rst_n),
        .i_d     (i_cs_n),
        .o_q     (cs_n_s)
    );

    spi_sync #(.RESET_VAL(1'b0)) u_sync_mosi (
        .i_clk_p (i_clk_p),
        .i_rst_n (i_rst_n),
        .i_d     (i_mosi),
        .o_q     (mosi_s)
    );

    // Edge-detect history flops
    logic sclk_prev_q;
    logic cs_n_prev_q;

    // Remember last synchronised sclk / cs_n level for edge detection
    always_ff @(posedge i_clk_p or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sclk_prev_q <= CPOL;
            cs_n_prev_q <= 1'b1;
        end else begin
            sclk_prev_q <= sclk_s;
            cs_n_prev_q <= cs_n_s;
        end
    end

    logic w_lead;
    logic w_trail;
    logic w_sample;
    logic w_shift;
    logic w_cs_fall;
    logic w_cs_rise;
    logic w_tx_accept;

    // Leading edge leaves the idle level, trailing edge returns to it
    assign w_lead      = (sclk_prev_q == CPOL) && (sclk_s != CPOL);
    assign w_trail     = (sclk_prev_q != CPOL) && (sclk_s == CPOL);
    assign w_sample    = CPHA ? w_trail : w_lead;
    assign w_shift     = CPHA ? w_lead  : w_trail;
    assign w_cs_fall   = cs_n_prev_q & ~cs_n_s;
    assign w_cs_rise   = ~cs_n_prev_q & cs_n_s;

    // Frame state
    state_t          state_q,     state_d;
    logic [N-1:0]    shreg_q,     shreg_d;
    logic            bit_q,       bit_d;
    logic [c_cw-1:0] cnt_q,       cnt_d;
    logic [N-1:0]    hold_q,      hold_d;
    logic            hold_full_q, hold_full_d;
    logic            miso_q,      miso_d;
    logic [N-1:0]    rx_data_q,   rx_data_d;
    logic            rx_valid_q,  rx_valid_d;
    logic            underrun_q,  underrun_d;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic            frame_err_q, frame_err_d;
`endif

    assign w_tx_accept = i_tx_valid & ~hold_full_q;

    // Next-state logic for the frame controller and TX holding register
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_d       = bit_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        miso_d      = miso_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        underrun_d  = 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
        frame_err_d = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (w_cs_fall) begin
                    cnt_d   = '0;
                    state_d = SHIFT;
                    if (hold_full_q) begin
                        shreg_d     = hold_q;
                        hold_full_d = 1'b0;
                    end else begin
                        shreg_d    = '0;
                        underrun_d = 1'b1;
                    end
                    // CPHA=0 presents bit 0 before the first sample edge;
                    // CPHA=1 waits for the first leading edge.
                    miso_d = (!CPHA && hold_full_q) ? hold_q[0] : 1'b0;
                end
            end

            SHIFT: begin
                if (w_cs_rise) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    miso_d  = 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
                    frame_err_d = (cnt_q != '0);
`endif
                end else if (w_sample) begin
                    bit_d = mosi_s;
                    if (cnt_q == c_last) begin
                        // Final bit merged straight into the delivered word
                        cnt_d      = '0;
                        rx_data_d  = {mosi_s, shreg_q[N-1:1]};
                        rx_valid_d = 1'b1;
                        state_d    = HOLD;
                    end else begin
                        cnt_d = cnt_q + c_cw'(1);
                    end
                end else if (w_shift) begin
                    if (CPHA && (cnt_q == '0)) begin
                        // First leading edge in CPHA=1 only presents bit 0
                        miso_d = shreg_q[0];
                    end else begin
                        shreg_d = {bit_q, shreg_q[N-1:1]};
                        miso_d  = shreg_q[1];
                    end
                end
            end

            HOLD: begin
                if (w_cs_rise) begin
                    state_d = IDLE;
                    miso_d  = 1'b0;
                end
`ifdef SPI_SLAVE_FRAME_ERR_EN
                else if (w_lead || w_trail) begin
                    frame_err_d = 1'b1;
                end
`endif
            end

            default: begin
                state_d = IDLE;
                miso_d  = 1'b0;
            end
        endcase

        // A word offered at frame start lands in the (just emptied) holder
        if (w_tx_accept) begin
            hold_d      = i_tx_data;
            hold_full_d = 1'b1;
        end
    end

    // State and output registers
    always_ff @(posedge i_clk_p or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            bit_q       <= 1'b0;
            cnt_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            miso_q      <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frame_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_q       <= bit_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            miso_q      <= miso_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frame_err_q <= frame_err_d;
`endif
        end
    end

    assign o_miso        = miso_q;
    assign o_busy        = (state_q != IDLE);
    assign o_miso_oe     = (state_q != IDLE);
    assign o_tx_ready    = ~hold_full_q;
    assign o_rx_data     = rx_data_q;
    assign o_rx_valid    = rx_valid_q;
    assign o_tx_underrun = underrun_q;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    assign o_frame_err   = frame_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave
// Description : Self-checking bench for spi_slave in mode 0 and mode 3, with
//               a receive scoreboard and a bit-banged SPI master.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave;

    localparam int N = 20;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // Mode 0 instance signals
    logic         sclk0 = 1'b0, cs0_n = 1'b1, mosi0 = 1'b0;
    logic [N-1:0] tx_data0 = '0;
    logic         tx_valid0 = 1'b0;
    logic         miso0, oe0, tx_ready0, rx_valid0, underrun0, busy0;
    logic [N-1:0] rx_data0;

    // Mode 3 instance signals
    logic         sclk3 = 1'b1, cs3_n = 1'b1, mosi3 = 1'b0;
    logic [N-1:0] tx_data3 = '0;
    logic         tx_valid3 = 1'b0;
    logic         miso3, oe3, tx_ready3, rx_valid3, underrun3, busy3;
    logic [N-1:0] rx_data3;

`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic fe0, fe3;
`endif

    spi_slave #(.N(N), .CPOL(1'b0), .CPHA(1'b0)) u_dut0 (
        .i_clk_p       (clk),
        .i_rst_n       (rst_n),
        .i_sclk        (sclk0),
        .i_cs_n        (cs0_n),
        .i_mosi        (mosi0),
        .o_miso        (miso0),
        .o_miso_oe     (oe0),
        .i_tx_data     (tx_data0),
        .i_tx_valid    (tx_valid0),
        .o_tx_ready    (tx_ready0),
        .o_rx_data     (rx_data0),
        .o_rx_valid    (rx_valid0),
        .o_tx_underrun (underrun0),
        .o_busy        (busy0)
`ifdef SPI_SLAVE_FRAME_ERR_EN
        ,
        .o_frame_err   (fe0)
`endif
    );

    spi_slave #(.N(N), .CPOL(1'b1), .CPHA(1'b1)) u_dut3 (
        .i_clk_p       (clk),
        .i_rst_n       (rst_n),
        .i_sclk        (sclk3),
        .i_cs_n        (cs3_n),
        .i_mosi        (mosi3),
        .o_miso        (miso3),
        .o_miso_oe     (oe3),
        .i_tx_data     (tx_data3),
        .i_tx_valid    (tx_valid3),
        .o_tx_ready    (tx_ready3),
        .o_rx_data     (rx_data3),
        .o_rx_valid    (rx_valid3),
        .o_tx_underrun (underrun3),
        .o_busy        (busy3)
`ifdef SPI_SLAVE_FRAME_ERR_EN
        ,
        .o_frame_err   (fe3)
`endif
    );

    int checks = 0;
    int errors = 0;

    logic [N-1:0] rxq0[$];
    logic [N-1:0] rxq3[$];
    logic [N-1:0] exp0, exp3;
    int  rxv0_cnt = 0, rxv3_cnt = 0, und0_cnt = 0, und3_cnt = 0;
    logic rxv0_prev = 1'b0, rxv3_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every rx_valid strobe pops one expected word
    always @(negedge clk) begin
        if (rst_n && rx_valid0) begin
            rxv0_cnt++;
            checks++;
            assert (rxv0_prev === 1'b0) else begin
                errors++;
                $error("FAIL rx_valid0_width observed=%b expected=0", rxv0_prev);
            end
            checks++;
            assert (rxq0.size() != 0) else begin
                errors++;
                $error("FAIL rx0_unexpected observed=%h expected=none", rx_data0);
            end
            if (rxq0.size() != 0) begin
                exp0 = rxq0.pop_front();
                checks++;
                assert (rx_data0 === exp0) else begin
                    errors++;
                    $error("FAIL rx0_data observed=%h expected=%h", rx_data0, exp0);
                end
            end
        end
        if (rst_n && rx_valid3) begin
            rxv3_cnt++;
            checks++;
            assert (rxv3_prev === 1'b0) else begin
                errors++;
                $error("FAIL rx_valid3_width observed=%b expected=0", rxv3_prev);
            end
            checks++;
            assert (rxq3.size() != 0) else begin
                errors++;
                $error("FAIL rx3_unexpected observed=%h expected=none", rx_data3);
            end
            if (rxq3.size() != 0) begin
                exp3 = rxq3.pop_front();
                checks++;
                assert (rx_data3 === exp3) else begin
                    errors++;
                    $error("FAIL rx3_data observed=%h expected=%h", rx_data3, exp3);
                end
            end
        end
        rxv0_prev = rx_valid0;
        rxv3_prev = rx_valid3;
        if (rst_n && underrun0) und0_cnt++;
        if (rst_n && underrun3) und3_cnt++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_tx(input bit m3, input logic [N-1:0] w);
        @(negedge clk);
        if (m3) begin tx_data3 = w; tx_valid3 = 1'b1; end
        else    begin tx_data0 = w; tx_valid0 = 1'b1; end
        @(negedge clk);
        tx_valid0 = 1'b0;
        tx_valid3 = 1'b0;
    endtask

    // Bit-banged master: SCLK half period = 8 system clocks, LSB first
    task automatic frame(input bit m3, input logic [N-1:0] mo, input int nbits,
                         input bit raise, output logic [N-1:0] mi, output bit unstable);
        mi       = '0;
        unstable = 1'b0;
        if (!m3) begin
            cs0_n = 1'b0;
            mosi0 = mo[0];
            for (int i = 0; i < nbits; i++) begin
                wait_clk(8);
                sclk0 = 1'b1;
                mi[i] = miso0;
                wait_clk(8);
                sclk0 = 1'b0;
                if (i + 1 < N) mosi0 = mo[i+1];
            end
            wait_clk(8);
            if (raise) cs0_n = 1'b1;
        end else begin
            cs3_n = 1'b0;
            for (int i = 0; i < nbits; i++) begin
                wait_clk(8);
                sclk3 = 1'b0;
                mosi3 = mo[i];
                wait_clk(8);
                sclk3 = 1'b1;
                mi[i] = miso3;
                wait_clk(4);
                if (miso3 !== mi[i]) unstable = 1'b1;
            end
            wait_clk(8);
            if (raise) cs3_n = 1'b1;
        end
        wait_clk(8);
    endtask

    task automatic check_reset_values();
        check("rst_miso",     {31'd0, miso0},     32'd0);
        check("rst_miso_oe",  {31'd0, oe0},       32'd0);
        check("rst_rx_data",  {12'd0, rx_data0},  32'd0);
        check("rst_rx_valid", {31'd0, rx_valid0}, 32'd0);
        check("rst_tx_ready", {31'd0, tx_ready0}, 32'd1);
        check("rst_underrun", {31'd0, underrun0}, 32'd0);
        check("rst_busy",     {31'd0, busy0},     32'd0);
    endtask

    logic [N-1:0] mi, mi1;
    bit           uns, uns1;
    int           v, u;

    initial begin
        // Reset state
        wait_clk(4);
        check_reset_values();
        rst_n = 1'b1;
        wait_clk(4);

        // Mode 0 full frame with preload
        load_tx(1'b0, 20'hA5A5A);
        check("m0_tx_ready_after_load", {31'd0, tx_ready0}, 32'd0);
        rxq0.push_back(20'h3C3C3);
        v = rxv0_cnt;
        u = und0_cnt;
        frame(1'b0, 20'h3C3C3, N, 1'b1, mi, uns);
        check("m0_miso_word",   {12'd0, mi}, 32'h000A5A5A);
        check("m0_rxv_count",   rxv0_cnt - v, 32'd1);
        check("m0_no_underrun", und0_cnt - u, 32'd0);
        check("m0_tx_ready",    {31'd0, tx_ready0}, 32'd1);
        check("m0_busy_idle",   {31'd0, busy0},     32'd0);
        check("m0_oe_idle",     {31'd0, oe0},       32'd0);

        // Mode 3 full frame with preload, MISO stable across sample edges
        load_tx(1'b1, 20'hA5A5A);
        rxq3.push_back(20'h3C3C3);
        v = rxv3_cnt;
        frame(1'b1, 20'h3C3C3, N, 1'b1, mi, uns);
        check("m3_miso_word",   {12'd0, mi}, 32'h000A5A5A);
        check("m3_miso_stable", {31'd0, uns}, 32'd0);
        check("m3_rxv_count",   rxv3_cnt - v, 32'd1);
        check("m3_busy_idle",   {31'd0, busy3}, 32'd0);

        // Underrun: no preload
        rxq0.push_back(20'h3C3C3);
        u = und0_cnt;
        frame(1'b0, 20'h3C3C3, N, 1'b1, mi, uns);
        check("ur_miso_zero",     {12'd0, mi}, 32'd0);
        check("ur_underrun_once", und0_cnt - u, 32'd1);

        // Short frame of 7 bits: aborted, nothing delivered
        v = rxv0_cnt;
        frame(1'b0, 20'h7FFFF, 7, 1'b1, mi, uns);
        check("short_no_rxv",     rxv0_cnt - v, 32'd0);
        check("short_busy_idle",  {31'd0, busy0},     32'd0);
        check("short_tx_ready",   {31'd0, tx_ready0}, 32'd1);
        check("short_rx_kept",    {12'd0, rx_data0},  32'h0003C3C3);
        rxq0.push_back(20'h00001);
        v = rxv0_cnt;
        frame(1'b0, 20'h00001, N, 1'b1, mi, uns);
        check("after_short_rxv",  rxv0_cnt - v, 32'd1);

        // Back-to-back frames with a handshake during frame 1
        load_tx(1'b0, 20'h22222);
        rxq0.push_back(20'h0F0F0);
        rxq0.push_back(20'h13579);
        fork
            frame(1'b0, 20'h0F0F0, N, 1'b1, mi1, uns1);
            begin
                wait_clk(30);
                check("b2b_ready_mid_before", {31'd0, tx_ready0}, 32'd1);
                load_tx(1'b0, 20'h11111);
                wait_clk(2);
                check("b2b_ready_mid_after",  {31'd0, tx_ready0}, 32'd0);
            end
        join
        check("b2b_f1_miso",     {12'd0, mi1}, 32'h00022222);
        check("b2b_ready_gap",   {31'd0, tx_ready0}, 32'd0);
        frame(1'b0, 20'h13579, N, 1'b1, mi, uns);
        check("b2b_f2_miso",     {12'd0, mi}, 32'h00011111);
        check("b2b_ready_after", {31'd0, tx_ready0}, 32'd1);

        // Reset pulsed mid-frame after 10 bits
        load_tx(1'b0, 20'h12345);
        frame(1'b0, 20'h3C3C3, 10, 1'b0, mi, uns);
        #2 rst_n = 1'b0;
        #1;
        check_reset_values();
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(4);
        cs0_n = 1'b1;
        wait_clk(8);
        check("rst_mid_idle", {31'd0, busy0}, 32'd0);
        rxq0.push_back(20'hFFFFF);
        v = rxv0_cnt;
        frame(1'b0, 20'hFFFFF, N, 1'b1, mi, uns);
        check("post_rst_rxv",  rxv0_cnt - v, 32'd1);
        check("post_rst_miso", {12'd0, mi}, 32'd0);

        // Every expected word was consumed
        wait_clk(8);
        check("rxq0_drained", rxq0.size(), 32'd0);
        check("rxq3_drained", rxq3.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog
    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
